// File: rtl/tst_obs_pkg.sv
// Shared definitions for the test-observation controller.
// Contents: FSM state enum, capture-mode encodings, and the layout of the
// serially loaded configuration word
// (MSB..LSB: sel, trig_src, trig_val, mode, decim).
package tst_obs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } obs_state_t;

    localparam logic [1:0] MODE_LIVE = 2'd0;
    localparam logic [1:0] MODE_TRIG = 2'd1;
    localparam logic [1:0] MODE_IMM  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam int unsigned DECIM_W   = 4;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned DECIM_LSB = 0;
    localparam int unsigned MODE_LSB  = DECIM_W;
    localparam int unsigned TVAL_LSB  = DECIM_W + MODE_W;

    function automatic int unsigned tsrc_lsb(input int unsigned dw);
        return TVAL_LSB + dw;
    endfunction

    function automatic int unsigned sel_lsb(input int unsigned selw, input int unsigned dw);
        return TVAL_LSB + dw + selw;
    endfunction

    function automatic int unsigned cfg_width(input int unsigned selw, input int unsigned dw);
        return 2 * selw + dw + DECIM_W + MODE_W;
    endfunction

endpackage

// File: rtl/obs_capture_buf.sv
// Capture buffer: DEPTH x DW register array used as a FIFO.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             empty the buffer (pointers and count to 0)
//   wr_en, wr_data  append one sample (ignored when full or clearing)
//   rd_en           pop the oldest sample into rd_data (ignored when empty)
//   rd_data         registered readout, holds between pops
//   count, empty    occupancy
module obs_capture_buf #(
    parameter int unsigned DW    = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr_en && !clr && (count != FULL_CNT);
    assign do_rd = rd_en && !clr && (count != '0);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CNTW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/test_observe_ctrl.sv
// Test-observation controller: serially loaded config, live source mux and a
// trigger-qualified, decimated capture buffer with post-capture readout.
// Ports:
//   inClock, inReset            clock, asynchronous active-low reset
//   inSrcData                   N_SRC packed DW-bit sources
//   inCfgShiftEn, inCfgSerial   config shift chain (enters at MSB)
//   outCfgSerial                chain LSB (scan-out)
//   inCfgLatch, outCfgReject    copy chain to active config / refused pulse
//   inArm, inReadEnable         start capture / pop one sample
//   outLive                     registered selected source
//   outData, outCount, outEmpty readout data and occupancy
//   outState                    FSM state
module test_observe_ctrl
    import tst_obs_pkg::*;
#(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned DW    = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    inClock,
    input  logic                    inReset,
    input  logic [N_SRC*DW-1:0]     inSrcData,
    input  logic                    inCfgShiftEn,
    input  logic                    inCfgSerial,
    output logic                    outCfgSerial,
    input  logic                    inCfgLatch,
    output logic                    outCfgReject,
    input  logic                    inArm,
    input  logic                    inReadEnable,
    output logic [DW-1:0]           outLive,
    output logic [DW-1:0]           outData,
    output logic [1:0]              outState,
    output logic [$clog2(DEPTH):0]  outCount,
    output logic                    outEmpty
);

    localparam int unsigned SELW     = $clog2(N_SRC);
    localparam int unsigned CFG_W    = cfg_width(SELW, DW);
    localparam int unsigned CNTW     = $clog2(DEPTH) + 1;
    localparam int unsigned SEL_LSB  = sel_lsb(SELW, DW);
    localparam int unsigned TSRC_LSB = tsrc_lsb(DW);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DEPTH - 1);

    logic [CFG_W-1:0]   chain;
    logic [CFG_W-1:0]   cfg;
    logic [SELW-1:0]    cfg_sel;
    logic [SELW-1:0]    cfg_tsrc;
    logic [DW-1:0]      cfg_tval;
    logic [1:0]         cfg_mode;
    logic [DECIM_W-1:0] cfg_decim;

    logic [DW-1:0]      src [N_SRC];
    logic [DW-1:0]      sel_data;
    logic               arm_ok;
    logic               busy;

    obs_state_t         state, state_nxt;
    logic [DECIM_W-1:0] dcnt, dcnt_nxt;
    logic               buf_clr, buf_wr, buf_rd;
    logic [CNTW-1:0]    buf_count;
    logic               buf_empty;

    assign cfg_sel   = cfg[SEL_LSB +: SELW];
    assign cfg_tsrc  = cfg[TSRC_LSB +: SELW];
    assign cfg_tval  = cfg[TVAL_LSB +: DW];
    assign cfg_mode  = cfg[MODE_LSB +: MODE_W];
    assign cfg_decim = cfg[DECIM_LSB +: DECIM_W];

    always_comb begin
        for (int unsigned k = 0; k < N_SRC; k++) begin
            src[k] = inSrcData[k*DW +: DW];
        end
    end

    assign sel_data = src[cfg_sel];
    // Reserved mode 3 behaves as live-only, so it never arms.
    assign arm_ok   = inArm && (cfg_mode == MODE_TRIG || cfg_mode == MODE_IMM);
    assign busy     = (state == ST_ARMED) || (state == ST_CAPTURE);

    // The decimation counter counts down to the next write; the trigger write
    // counts as a write, so the next one lands decim+1 cycles later.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        buf_clr   = 1'b0;
        buf_wr    = 1'b0;
        buf_rd    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm_ok) begin
                    buf_clr   = 1'b1;
                    dcnt_nxt  = '0;
                    state_nxt = (cfg_mode == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
                end else if (state == ST_DONE && inReadEnable && !buf_empty) begin
                    buf_rd = 1'b1;
                end
            end
            ST_ARMED: begin
                if (src[cfg_tsrc] == cfg_tval) begin
                    buf_wr    = 1'b1;
                    dcnt_nxt  = cfg_decim;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (dcnt == '0) begin
                    buf_wr   = 1'b1;
                    dcnt_nxt = cfg_decim;
                    if (buf_count == LAST_CNT) begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    dcnt_nxt = dcnt - DECIM_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state        <= ST_IDLE;
            dcnt         <= '0;
            chain        <= '0;
            cfg          <= '0;
            outLive      <= '0;
            outCfgReject <= 1'b0;
        end else begin
            state        <= state_nxt;
            dcnt         <= dcnt_nxt;
            outLive      <= sel_data;
            outCfgReject <= inCfgLatch && busy;
            // Latch copies the pre-shift chain since both use the old value.
            if (inCfgLatch && !busy) begin
                cfg <= chain;
            end
            if (inCfgShiftEn) begin
                chain <= {inCfgSerial, chain[CFG_W-1:1]};
            end
        end
    end

    obs_capture_buf #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (inClock),
        .rst_n   (inReset),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (sel_data),
        .rd_en   (buf_rd),
        .rd_data (outData),
        .count   (buf_count),
        .empty   (buf_empty)
    );

    assign outCfgSerial = chain[0];
    assign outState     = state;
    assign outCount     = buf_count;
    assign outEmpty     = buf_empty;

endmodule

// File: tb/tb_test_observe_ctrl.sv
// Bench for test_observe_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a queue-based behavioural model.
module tb_test_observe_ctrl;

    localparam int N_SRC = 8;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int W     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src_word = '0;
    logic        shift_en = 1'b0;
    logic        ser = 1'b0;
    logic        latch = 1'b0;
    logic        arm = 1'b0;
    logic        rd = 1'b0;
    logic        cfg_so;
    logic        reject;
    logic [3:0]  live;
    logic [3:0]  data;
    logic [1:0]  st;
    logic [4:0]  cnt;
    logic        empty;

    int checks = 0;
    int errors = 0;

    // behavioural model
    int m_chain, m_cfg, m_state, m_wait, m_live, m_data, m_rej;
    int q[$];

    always #5 clk = ~clk;

    test_observe_ctrl #(
        .N_SRC (N_SRC),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .inClock      (clk),
        .inReset      (rst_n),
        .inSrcData    (src_word),
        .inCfgShiftEn (shift_en),
        .inCfgSerial  (ser),
        .outCfgSerial (cfg_so),
        .inCfgLatch   (latch),
        .outCfgReject (reject),
        .inArm        (arm),
        .inReadEnable (rd),
        .outLive      (live),
        .outData      (data),
        .outState     (st),
        .outCount     (cnt),
        .outEmpty     (empty)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int src_of(input int k);
        return int'((src_word >> (k * DW)) & 32'hF);
    endfunction

    function automatic int mk(input int sel, input int ts, input int tv, input int mode, input int dec);
        return (sel << 13) | (ts << 10) | (tv << 6) | (mode << 4) | dec;
    endfunction

    task automatic model_reset();
        m_chain = 0; m_cfg = 0; m_state = 0; m_wait = 0;
        m_live = 0; m_data = 0; m_rej = 0;
        q.delete();
    endtask

    task automatic model_edge();
        int sel, ts, tv, mode, dec, old_state;
        bit arm_ok;
        sel  = (m_cfg >> 13) & 7;
        ts   = (m_cfg >> 10) & 7;
        tv   = (m_cfg >> 6) & 15;
        mode = (m_cfg >> 4) & 3;
        dec  = m_cfg & 15;
        arm_ok = arm && (mode == 1 || mode == 2);
        old_state = m_state;
        m_rej  = (latch && (old_state == 1 || old_state == 2)) ? 1 : 0;
        m_live = src_of(sel);
        case (old_state)
            0, 3: begin
                if (arm_ok) begin
                    q.delete();
                    m_wait  = 0;
                    m_state = (mode == 1) ? 1 : 2;
                end else if (old_state == 3 && rd && q.size() > 0) begin
                    m_data = q.pop_front();
                end
            end
            1: begin
                if (src_of(ts) == tv) begin
                    q.push_back(src_of(sel));
                    m_wait  = dec;
                    m_state = 2;
                end
            end
            default: begin
                if (m_wait == 0) begin
                    q.push_back(src_of(sel));
                    m_wait = dec;
                    if (q.size() == DEPTH) m_state = 3;
                end else begin
                    m_wait--;
                end
            end
        endcase
        if (latch && (old_state == 0 || old_state == 3)) m_cfg = m_chain;
        if (shift_en) m_chain = ((m_chain >> 1) | (int'(ser) << (W - 1))) & 16'hFFFF;
    endtask

    task automatic check_all();
        check("live",   live,   m_live);
        check("state",  st,     m_state);
        check("count",  cnt,    q.size());
        check("empty",  empty,  (q.size() == 0) ? 1 : 0);
        check("data",   data,   m_data);
        check("cfg_so", cfg_so, m_chain & 1);
        check("reject", reject, m_rej);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic load_cfg(input int word);
        for (int i = 0; i < W; i++) begin
            shift_en = 1'b1;
            ser = 1'((word >> i) & 1);
            step();
        end
        shift_en = 1'b0;
        ser = 1'b0;
        latch = 1'b1;
        step();
        latch = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (st != 2'd3 && n < budget) begin
            src_word = $urandom;
            step();
            n++;
        end
        check("done_timeout", (st == 2'd3) ? 1 : 0, 1);
    endtask

    task automatic set_src(input int k, input int v);
        src_word[k*DW +: DW] = 4'(v);
    endtask

    initial begin
        int rb;
        model_reset();
        #3;
        check_all();
        rst_n = 1'b1;

        // 1: config load and scan-out readback
        load_cfg(16'h1234);
        rb = 0;
        for (int i = 0; i < W; i++) begin
            rb = rb | (int'(cfg_so) << i);
            shift_en = 1'b1;
            ser = 1'b0;
            step();
        end
        shift_en = 1'b0;
        check("t1_readback", rb, 16'h1234);

        // 2: live only
        load_cfg(mk(5, 0, 0, 0, 0));
        src_word = 32'h00A0_0000;
        step();
        check("t2_live", live, 4'hA);
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        check("t2_state", st, 0);

        // 3: immediate capture, decim 0, counting source
        load_cfg(mk(2, 0, 0, 2, 0));
        src_word = '0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            set_src(2, i & 15);
            if (i == DEPTH) check("t3_not_done_early", st, 2);
            step();
        end
        check("t3_done", st, 3);
        rd = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check("t3_read", data, (i + 1) & 15);
        end
        step();
        rd = 1'b0;
        check("t3_read_empty_hold", data, 0);
        check("t3_empty", empty, 1);

        // 4: trigger capture, decim 2
        load_cfg(mk(1, 3, 7, 1, 2));
        arm = 1'b1;
        src_word = '0;
        step();
        arm = 1'b0;
        check("t4_armed", st, 1);
        for (int i = 0; i < 5; i++) begin
            src_word = $urandom;
            if (src_word[15:12] == 4'h7) src_word[15:12] = 4'h0;
            step();
        end
        check("t4_still_armed", st, 1);
        src_word = $urandom;
        src_word[15:12] = 4'h7;
        step();
        for (int i = 1; i <= 45; i++) begin
            src_word = $urandom;
            step();
            if (i == 44) check("t4_capture_T44", st, 2);
        end
        check("t4_done_T45", st, 3);
        rd = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        rd = 1'b0;
        check("t4_drained", empty, 1);

        // 5: latch rejected while armed, accepted in done
        arm = 1'b1;
        src_word = '0;
        step();
        arm = 1'b0;
        for (int i = 0; i < W; i++) begin
            shift_en = 1'b1;
            ser = 1'((mk(6, 0, 0, 2, 1) >> i) & 1);
            step();
        end
        shift_en = 1'b0;
        latch = 1'b1;
        step();
        latch = 1'b0;
        check("t5_reject", reject, 1);
        step();
        check("t5_reject_one", reject, 0);
        run_to_done(200);
        latch = 1'b1;
        step();
        latch = 1'b0;
        check("t5_accept", reject, 0);
        src_word = $urandom;
        step();
        step();
        check("t5_new_sel", live, src_word[27:24]);

        // 6: asynchronous reset mid-capture
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            src_word = $urandom;
            step();
        end
        check("t6_pre_cnt_nz", (cnt != 0) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
        step();
        check("t6_cnt", cnt, 0);
        check("t6_state", st, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            src_word = $urandom;
            shift_en = ($urandom_range(0, 3) == 0);
            ser      = 1'($urandom);
            latch    = ($urandom_range(0, 15) == 0);
            arm      = ($urandom_range(0, 11) == 0);
            rd       = ($urandom_range(0, 1) == 0);
            step();
        end
        shift_en = 1'b0;
        latch = 1'b0;
        arm = 1'b0;
        rd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
